// File: rtl/bus_arbiter.sv
// Shared memory-bus sequencer for the fetch (IF) and load/store (MEM) requesters.
// MEM has strict priority; partial-word stores become a read-modify-write pair.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_stall_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_stall_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [2:0] {
    IDLE, IF_RD, MEM_RD, RMW_RD, RMW_WR, MEM_WR, IF_DONE, MEM_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_discard;
  logic [31:0]      r_rword;

  logic             w_ack;
  logic             w_timeout;
  logic [31:0]      w_merge;
  logic [31:0]      w_mem_waddr;
  logic [31:0]      w_if_waddr;

  assign w_ack       = bus_stb_o & bus_ack_i;
  assign w_timeout   = bus_stb_o & ~bus_ack_i & (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_mem_waddr = mem_addr_i & ~32'h3;
  assign w_if_waddr  = if_addr_i & ~32'h3;

  assign mem_stall_o = mem_ce_i & (r_state != MEM_DONE);
  assign if_stall_o  = if_ce_i & (r_state != IF_DONE);

  always_comb begin
    w_merge = r_rword;
    for (int unsigned i = 0; i < 4; i++) begin
      if (mem_sel_i[i]) w_merge[8*i +: 8] = mem_data_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_discard  <= 1'b0;
      r_rword    <= '0;
      bus_cyc_o  <= 1'b0;
      bus_stb_o  <= 1'b0;
      bus_we_o   <= 1'b0;
      bus_addr_o <= '0;
      bus_sel_o  <= '0;
      bus_data_o <= '0;
      bus_err_o  <= 1'b0;
      if_data_o  <= '0;
      mem_data_o <= '0;
    end else begin
      bus_err_o <= 1'b0;
      if (bus_stb_o && !bus_ack_i && !w_timeout) r_cnt <= r_cnt + 1'b1;
      else                                      r_cnt <= '0;

      case (r_state)
        IDLE: begin
          if (mem_ce_i) begin
            bus_cyc_o <= 1'b1;
            bus_stb_o <= 1'b1;
            if (!mem_we_i) begin
              r_state    <= MEM_RD;
              bus_we_o   <= 1'b0;
              bus_addr_o <= w_mem_waddr;
              bus_sel_o  <= '1;
              bus_data_o <= '0;
            end else if (&mem_sel_i) begin
              r_state    <= MEM_WR;
              bus_we_o   <= 1'b1;
              bus_addr_o <= mem_addr_i;
              bus_sel_o  <= mem_sel_i;
              bus_data_o <= mem_data_i;
            end else begin
              r_state    <= RMW_RD;
              bus_we_o   <= 1'b0;
              bus_addr_o <= w_mem_waddr;
              bus_sel_o  <= '1;
              bus_data_o <= '0;
            end
          end else if (if_ce_i) begin
            r_state    <= IF_RD;
            bus_cyc_o  <= 1'b1;
            bus_stb_o  <= 1'b1;
            bus_we_o   <= 1'b0;
            bus_addr_o <= w_if_waddr;
            bus_sel_o  <= '1;
            bus_data_o <= '0;
          end
        end

        IF_RD: begin
          if (w_ack || w_timeout) begin
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            bus_err_o <= w_timeout;
            r_discard <= 1'b0;
            if (r_discard) begin
              r_state <= IDLE;
            end else begin
              r_state   <= IF_DONE;
              if_data_o <= w_ack ? bus_data_i : '0;
            end
          end else if (flush_i) begin
            r_discard <= 1'b1;
          end
        end

        MEM_RD: begin
          if (w_ack || w_timeout) begin
            bus_cyc_o  <= 1'b0;
            bus_stb_o  <= 1'b0;
            bus_err_o  <= w_timeout;
            r_state    <= MEM_DONE;
            mem_data_o <= w_ack ? bus_data_i : '0;
          end
        end

        RMW_RD: begin
          if (w_ack) begin
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            r_rword   <= bus_data_i;
            r_state   <= RMW_WR;
          end else if (w_timeout) begin
            bus_cyc_o  <= 1'b0;
            bus_stb_o  <= 1'b0;
            bus_err_o  <= 1'b1;
            r_state    <= MEM_DONE;
            mem_data_o <= '0;
          end
        end

        RMW_WR: begin
          // stb is low only in the first RMW_WR cycle: that is the gap before the write
          if (!bus_stb_o) begin
            bus_cyc_o  <= 1'b1;
            bus_stb_o  <= 1'b1;
            bus_we_o   <= 1'b1;
            bus_sel_o  <= '1;
            bus_data_o <= w_merge;
          end else if (w_ack || w_timeout) begin
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            bus_err_o <= w_timeout;
            r_state   <= MEM_DONE;
            if (w_timeout) mem_data_o <= '0;
          end
        end

        MEM_WR: begin
          if (w_ack || w_timeout) begin
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            bus_err_o <= w_timeout;
            r_state   <= MEM_DONE;
            if (w_timeout) mem_data_o <= '0;
          end
        end

        IF_DONE, MEM_DONE: r_state <= IDLE;

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with hand-computed values, then a randomized run.
module tb_bus_arbiter;
  localparam int unsigned TO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i, if_ce_i, mem_ce_i, mem_we_i, bus_ack_i;
  logic [31:0] if_addr_i, mem_addr_i, mem_data_i, bus_data_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] if_data_o, mem_data_o, bus_addr_o, bus_data_o;
  logic        if_stall_o, mem_stall_o, bus_cyc_o, bus_stb_o, bus_we_o, bus_err_o;
  logic [3:0]  bus_sel_o;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_stall_o(if_stall_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .mem_stall_o(mem_stall_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_data_o(bus_data_o), .bus_data_i(bus_data_i),
    .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: which operation owns the bus and what the bus must show.
  typedef enum int {OP_NONE, OP_FETCH, OP_LOAD, OP_STORE, OP_RMWR, OP_GAP, OP_RMWW} op_t;
  op_t         m_op;
  int          m_done;  // 0: none, 1: fetch result this cycle, 2: load/store result this cycle
  int unsigned m_wcnt;
  bit          m_disc;
  logic [31:0] m_rword;
  logic        e_stb, e_we, e_err;
  logic [31:0] e_addr, e_wdata, e_ifd, e_memd;
  logic [3:0]  e_sel;

  // Slave behaviour
  bit          rnd_mode;
  bit          sl_never;
  int unsigned sl_wait;
  int unsigned dir_wait;
  logic [31:0] dir_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    m_op = OP_NONE; m_done = 0; m_wcnt = 0; m_disc = 0; m_rword = '0;
    e_stb = 0; e_we = 0; e_err = 0; e_addr = '0; e_wdata = '0; e_sel = '0;
    e_ifd = '0; e_memd = '0;
  endtask

  task automatic m_launch(input op_t op, input logic [31:0] a, input logic we,
                          input logic [3:0] sel, input logic [31:0] d);
    m_op = op; e_stb = 1; e_addr = a; e_we = we; e_sel = sel; e_wdata = d; m_wcnt = 0;
    sl_wait = rnd_mode ? $urandom_range(0, 3) : dir_wait;
  endtask

  // Effect of one rising edge, given the inputs of the cycle that just ended.
  task automatic m_step();
    bit old_disc, tmo;
    logic [31:0] mask;
    e_err = 1'b0;
    if (!rst) begin m_reset(); return; end
    if (m_done != 0) begin m_done = 0; return; end
    case (m_op)
      OP_NONE: begin
        if (mem_ce_i) begin
          if (!mem_we_i)              m_launch(OP_LOAD, mem_addr_i & ~32'h3, 1'b0, 4'hF, '0);
          else if (mem_sel_i == 4'hF) m_launch(OP_STORE, mem_addr_i, 1'b1, mem_sel_i, mem_data_i);
          else                        m_launch(OP_RMWR, mem_addr_i & ~32'h3, 1'b0, 4'hF, '0);
        end else if (if_ce_i) begin
          m_launch(OP_FETCH, if_addr_i & ~32'h3, 1'b0, 4'hF, '0);
        end
      end
      OP_GAP: begin
        mask = {{8{mem_sel_i[3]}}, {8{mem_sel_i[2]}}, {8{mem_sel_i[1]}}, {8{mem_sel_i[0]}}};
        m_launch(OP_RMWW, e_addr, 1'b1, 4'hF, (mem_data_i & mask) | (m_rword & ~mask));
      end
      default: begin
        old_disc = m_disc;
        if (m_op == OP_FETCH && flush_i) m_disc = 1;
        if (!bus_ack_i && (m_wcnt + 1 < TO)) begin
          m_wcnt++;
        end else begin
          tmo = !bus_ack_i;
          e_stb = 0;
          e_err = tmo;
          case (m_op)
            OP_FETCH: begin
              m_disc = 0; m_op = OP_NONE;
              if (!old_disc) begin m_done = 1; e_ifd = tmo ? '0 : bus_data_i; end
            end
            OP_RMWR: begin
              if (tmo) begin m_op = OP_NONE; m_done = 2; e_memd = '0; end
              else begin m_rword = bus_data_i; m_op = OP_GAP; end
            end
            OP_LOAD: begin m_op = OP_NONE; m_done = 2; e_memd = tmo ? '0 : bus_data_i; end
            default: begin m_op = OP_NONE; m_done = 2; if (tmo) e_memd = '0; end
          endcase
        end
      end
    endcase
  endtask

  // One cycle: drive slave, compare against the model, advance the model.
  task automatic tick();
    if (e_stb) begin
      bus_ack_i = !sl_never && (sl_wait == 0);
      if (!bus_ack_i && sl_wait > 0) sl_wait--;
    end else begin
      bus_ack_i = rnd_mode && ($urandom_range(0, 7) == 0);
    end
    bus_data_i = rnd_mode ? $urandom : dir_rdata;
    #1;
    chk("cyc", bus_cyc_o, e_stb);
    chk("stb", bus_stb_o, e_stb);
    chk("err", bus_err_o, e_err);
    chk("if_data", if_data_o, e_ifd);
    chk("mem_data", mem_data_o, e_memd);
    chk("mem_stall", mem_stall_o, mem_ce_i & (m_done != 2));
    chk("if_stall", if_stall_o, if_ce_i & (m_done != 1));
    if (e_stb) begin
      chk("we", bus_we_o, e_we);
      chk("addr", bus_addr_o, e_addr);
      chk("sel", bus_sel_o, e_sel);
      if (e_we) chk("wdata", bus_data_o, e_wdata);
    end
    m_step();
    @(negedge clk);
    #1;
  endtask

  int  n_stb;
  bit  dn_m, dn_i, mem_busy;

  initial begin
    m_reset();
    rnd_mode = 0; sl_never = 0; sl_wait = 0; dir_wait = 0; dir_rdata = '0;
    rst = 1'b0; flush_i = 0; if_ce_i = 0; mem_ce_i = 0; mem_we_i = 0; bus_ack_i = 0;
    if_addr_i = '0; mem_addr_i = '0; mem_data_i = '0; mem_sel_i = '0; bus_data_i = '0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_cyc", bus_cyc_o, 1'b0);
    chk("rst_stb", bus_stb_o, 1'b0);
    chk("rst_we", bus_we_o, 1'b0);
    chk("rst_addr", bus_addr_o, 32'h0);
    chk("rst_sel", bus_sel_o, 4'h0);
    chk("rst_wdata", bus_data_o, 32'h0);
    chk("rst_err", bus_err_o, 1'b0);
    chk("rst_ifd", if_data_o, 32'h0);
    chk("rst_memd", mem_data_o, 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // Load, two wait states
    mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h8000_0104; dir_wait = 2; dir_rdata = 32'hDEAD_BEEF;
    tick();
    n_stb = 0;
    for (int k = 0; k < 3; k++) begin
      chk("ld_addr", bus_addr_o, 32'h8000_0104);
      chk("ld_stall", mem_stall_o, 1'b1);
      if (bus_stb_o) n_stb++;
      tick();
    end
    chk("ld_stb_cycles", n_stb, 3);
    chk("ld_data", mem_data_o, 32'hDEAD_BEEF);
    chk("ld_done_stall", mem_stall_o, 1'b0);
    mem_ce_i = 0;
    tick();

    // Byte store as read-modify-write
    mem_ce_i = 1; mem_we_i = 1; mem_sel_i = 4'b0010; mem_data_i = 32'h0000_AB00;
    mem_addr_i = 32'h0000_0010; dir_wait = 0; dir_rdata = 32'h1122_3344;
    tick();
    chk("rmw_rd_stb", bus_stb_o, 1'b1);
    chk("rmw_rd_we", bus_we_o, 1'b0);
    chk("rmw_rd_sel", bus_sel_o, 4'hF);
    tick();
    chk("rmw_gap_cyc", bus_cyc_o, 1'b0);
    tick();
    chk("rmw_wr_stb", bus_stb_o, 1'b1);
    chk("rmw_wr_we", bus_we_o, 1'b1);
    chk("rmw_wr_sel", bus_sel_o, 4'hF);
    chk("rmw_wr_data", bus_data_o, 32'h1122_AB44);
    tick();
    chk("rmw_done_stall", mem_stall_o, 1'b0);
    mem_ce_i = 0;
    tick();

    // Contention: MEM first, fetch afterwards
    mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h1000_0008;
    if_ce_i = 1; if_addr_i = 32'h2000_0006; dir_rdata = 32'h0BAD_F00D; dir_wait = 0;
    tick();
    chk("ct_addr_mem", bus_addr_o, 32'h1000_0008);
    chk("ct_if_stall1", if_stall_o, 1'b1);
    tick();
    chk("ct_mem_done", mem_stall_o, 1'b0);
    chk("ct_if_stall2", if_stall_o, 1'b1);
    mem_ce_i = 0;
    tick();
    chk("ct_idle_stb", bus_stb_o, 1'b0);
    chk("ct_if_stall3", if_stall_o, 1'b1);
    tick();
    chk("ct_addr_if", bus_addr_o, 32'h2000_0004);
    tick();
    chk("ct_if_done", if_stall_o, 1'b0);
    chk("ct_if_data", if_data_o, 32'h0BAD_F00D);
    if_ce_i = 0;
    tick();

    // Flush during a fetch discards its result
    if_ce_i = 1; if_addr_i = 32'h0000_0100; dir_wait = 3; dir_rdata = 32'hCAFE_F00D;
    tick();
    tick();
    flush_i = 1;
    tick();
    flush_i = 0;
    tick();
    tick();
    chk("fl_no_done_stb", bus_stb_o, 1'b0);
    chk("fl_stall", if_stall_o, 1'b1);
    chk("fl_data_kept", if_data_o, 32'h0BAD_F00D);
    dir_wait = 0; dir_rdata = 32'h1357_9BDF;
    tick();
    chk("fl_stall2", if_stall_o, 1'b1);
    tick();
    chk("fl_new_done", if_stall_o, 1'b0);
    chk("fl_new_data", if_data_o, 32'h1357_9BDF);
    if_ce_i = 0;
    tick();

    // Timeout: slave never answers
    mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h0000_0300; sl_never = 1;
    tick();
    n_stb = 0;
    for (int k = 0; k < 300; k++) begin
      if (!bus_stb_o) break;
      n_stb++;
      tick();
    end
    chk("to_stb_cycles", n_stb, 255);
    chk("to_err", bus_err_o, 1'b1);
    chk("to_data", mem_data_o, 32'h0);
    chk("to_stall", mem_stall_o, 1'b0);
    mem_ce_i = 0; sl_never = 0;
    tick();
    chk("to_err_pulse", bus_err_o, 1'b0);

    // Reset in the middle of a write
    mem_ce_i = 1; mem_we_i = 1; mem_sel_i = 4'hF; mem_addr_i = 32'h0000_0040;
    mem_data_i = 32'h55AA_55AA; dir_wait = 5;
    tick();
    tick();
    chk("rw_stb_before", bus_stb_o, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("rw_cyc", bus_cyc_o, 1'b0);
    chk("rw_stb", bus_stb_o, 1'b0);
    chk("rw_we", bus_we_o, 1'b0);
    m_reset();
    mem_ce_i = 0;
    @(negedge clk); #1;
    tick();
    rst = 1'b1;
    tick();
    mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h0000_0200; dir_rdata = 32'h600D_D00D; dir_wait = 1;
    tick();
    tick();
    tick();
    chk("rw_load_data", mem_data_o, 32'h600D_D00D);
    chk("rw_load_stall", mem_stall_o, 1'b0);
    mem_ce_i = 0;
    tick();

    // Randomized traffic
    rnd_mode = 1; dn_m = 0; dn_i = 0;
    for (int n = 0; n < 4000; n++) begin
      mem_busy = (m_op inside {OP_LOAD, OP_STORE, OP_RMWR, OP_GAP, OP_RMWW}) || (m_done == 2);
      if (mem_ce_i) begin
        if (dn_m || $urandom_range(0, 39) == 0) mem_ce_i = 0;
      end else if (!mem_busy && $urandom_range(0, 3) == 0) begin
        mem_ce_i   = 1;
        mem_we_i   = 1'($urandom_range(0, 1));
        mem_sel_i  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
        mem_addr_i = $urandom;
        mem_data_i = $urandom;
      end
      if (if_ce_i) begin
        if (dn_i || $urandom_range(0, 49) == 0) if_ce_i = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        if_ce_i   = 1;
        if_addr_i = $urandom;
      end
      flush_i = ($urandom_range(0, 7) == 0);
      dn_m = (m_done == 2);
      dn_i = (m_done == 1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Sequences the single shared memory bus between the instruction-fetch requester (IF) and the load/store requester (MEM).
- Applies strict MEM priority.
- Converts partial-word stores into read-modify-write (RMW) sequences.
- Drives the pipeline stall requests.
- Sits between the IF/MEM stages and the external req/ack memory bus.

Parameters:
- TIMEOUT, 255: bus cycles a strobe may wait for ack before the transaction aborts with an error.
- CNT_W, 8: counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- flush_i  in  1  pipeline flush; discards a pending fetch result
- if_ce_i  in  1  fetch request
- if_addr_i  in  32  fetch address
- if_data_o  out  32  fetched instruction, valid while in IF_DONE
- if_stall_o  out  1  fetch stall request
- mem_ce_i  in  1  load/store request
- mem_we_i  in  1  1 = store
- mem_addr_i  in  32  load/store address
- mem_sel_i  in  4  byte-lane enables
- mem_data_i  in  32  store data
- mem_data_o  out  32  load data, valid while in MEM_DONE
- mem_stall_o  out  1  load/store stall request
- bus_cyc_o  out  1  bus cycle active
- bus_stb_o  out  1  bus strobe
- bus_we_o  out  1  bus write
- bus_addr_o  out  32  bus address
- bus_sel_o  out  4  bus byte lanes
- bus_data_o  out  32  bus write data
- bus_data_i  in  32  bus read data
- bus_ack_i  in  1  bus acknowledge
- bus_err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All bus_* outputs, bus_err_o, if_data_o and mem_data_o are 0.
  - Timeout counter and discard flag are cleared.
  - cyc/stb drop immediately, even mid-transaction.
- Reset release: a clean IDLE start on the next clk.
- States: IDLE, IF_RD, MEM_RD, RMW_RD, RMW_WR, MEM_WR, IF_DONE, MEM_DONE.
- All bus outputs are registered. A transaction launches on the clock edge that leaves IDLE; cyc=stb=1 from the next cycle.
- IDLE arbitration (MEM strictly wins):
  - mem_ce_i & !mem_we_i -> MEM_RD.
  - mem_ce_i & mem_we_i & sel=1111 -> MEM_WR.
  - mem_ce_i & mem_we_i & sel!=1111 -> RMW_RD.
  - Otherwise, if if_ce_i -> IF_RD.
  - Otherwise stay in IDLE.
- Read states (IF_RD, MEM_RD, RMW_RD): we=0, sel=1111, addr = requester address with bits[1:0] forced to 0.
- MEM_WR: we=1, sel=mem_sel_i, data=mem_data_i.
- Handshake:
  - stb/cyc are held with stable addr, data and sel until bus_ack_i is sampled high.
  - On that edge, cyc/stb clear and read data is latched.
  - A transaction is never aborted on flush or on a dropped request; only reset or timeout ends it early.
- Completion transitions on ack:
  - IF_RD -> IF_DONE, latching if_data_o. If the discard flag is set, go to IDLE instead.
  - MEM_RD -> MEM_DONE, latching mem_data_o.
  - RMW_RD -> RMW_WR, latching the read word R.
  - MEM_WR and RMW_WR -> MEM_DONE.
- RMW_WR:
  - we=1, sel=1111.
  - Data = per byte lane: mem_data_i where mem_sel_i=1, else R.
  - RMW_WR is entered with cyc/stb deasserted for exactly one cycle between the two transactions.
- DONE states last one cycle and then return to IDLE.
  - The next arbitration occurs in IDLE, so back-to-back requests have one idle bus cycle between them.
- Stalls (combinational):
  - mem_stall_o = mem_ce_i & (state != MEM_DONE).
  - if_stall_o = if_ce_i & (state != IF_DONE).
  - A fetch that is pending while MEM is served stays stalled.
- Load latency with a 0-wait slave (ack in the first stb cycle): the request is seen in IDLE at cycle 0, stb at cycle 1, MEM_DONE at cycle 2, stall low at cycle 2.
- Full-word store: same latency as a load.
- Partial store: cycle 4, with a 0-wait slave.
- Discard flag:
  - Set by flush_i while in IF_RD.
  - Cleared on leaving IF_RD.
  - flush_i in any other state has no effect.
- Timeout:
  - The counter increments each cycle stb=1 & ack=0 and clears when stb=0.
  - At count==TIMEOUT: drop cyc/stb, pulse bus_err_o, and go to the corresponding DONE state with data_o=0. From RMW_RD, go to MEM_DONE and skip the write.
- Request dropped mid-transaction (ce_i falls): the transaction completes, the DONE state still occurs, and the result is ignored.
- ack while stb=0: ignored.

Test Plan:
- Load, slave acks after 2 waits: mem_ce=1, we=0, addr=0x80000104, bus_data_i=0xDEADBEEF -> bus_addr_o=0x80000104, stb high for 3 cycles, mem_data_o=0xDEADBEEF in MEM_DONE, mem_stall_o=0 exactly in that cycle.
- Byte store: mem_sel=0010, mem_data_i=0x0000AB00, memory word=0x11223344 -> one read, one idle cycle, then write sel=1111 data=0x1122AB44.
- Contention: if_ce and mem_ce raised in the same cycle -> MEM transaction first, if_stall_o=1 throughout; IF_RD starts after MEM_DONE plus IDLE.
- Flush: flush_i asserted mid-IF_RD -> bus cycle completes on ack, no IF_DONE cycle, if_data_o unchanged, if_stall_o stays 1 until a new fetch completes.
- Timeout: slave never acks, TIMEOUT=255 -> stb high for 255 cycles, then bus_err_o pulses for 1 cycle, mem_data_o=0, FSM returns to IDLE.
- Reset mid-write: rst low during MEM_WR stb -> cyc/stb/we are 0 within the same cycle (asynchronous), state=IDLE; after release, a fresh load completes normally.
